pipe_mac: RTL and testbench

PIPE_MAC -- requirements
Module: pipe_mac

---
 rtl/pipe_mac.sv | 99 +++++++++
 tb/tb_pipe_mac.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_mac.sv
// Fully pipelined unsigned/signed multiplier with a signed accumulator.
// The accumulator is touched only at the completion stage, so back-to-back SMAC/ACLR chain with no hazard.
module pipe_mac #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  input  logic                        flush,
  output logic                        done,
  output logic [2*WIDTH-1:0]          result,
  output logic                        acc_ovf,
  output logic [$clog2(STAGES+2)-1:0] inflight
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(STAGES + 2);

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMAC = 2'b10;
  localparam logic [1:0] OP_ACLR = 2'b11;

  typedef struct packed {
    logic [1:0]    op;
    logic [PW-1:0] prod;
  } stage_t;

  logic [STAGES:0] vld_pipe;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    a_x, b_x, prod;
  stage_t           st [1:STAGES];
  stage_t           cmp;
  logic             cvld;
  logic [PW-1:0]    acc, sum;
  logic             ovf_det;

  // flush drops everything already in flight but still admits this edge's issue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else if (flush) vld_pipe <= {{STAGES{1'b0}}, start};
    else vld_pipe <= {vld_pipe[STAGES-1:0], start};

  always_ff @(posedge clk)
    if (start) begin
      op_q <= op;
      a_q  <= A;
      b_q  <= B;
    end

  // One multiplier: the low 2W bits of a product of extended operands are the
  // same for signed and unsigned; only the extension bit differs.
  assign a_x  = {{WIDTH{(op_q != OP_UMUL) & a_q[WIDTH-1]}}, a_q};
  assign b_x  = {{WIDTH{(op_q != OP_UMUL) & b_q[WIDTH-1]}}, b_q};
  assign prod = a_x * b_x;

  always_ff @(posedge clk) begin
    st[1] <= '{op: op_q, prod: prod};
    for (int i = 2; i <= STAGES; i++) st[i] <= st[i-1];
  end

  assign cmp     = st[STAGES];
  assign cvld    = vld_pipe[STAGES] & ~flush;
  assign sum     = acc + cmp.prod;
  assign ovf_det = (acc[PW-1] == cmp.prod[PW-1]) && (sum[PW-1] != acc[PW-1]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done    <= 1'b0;
      result  <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      done <= cvld;
      if (cvld) begin
        case (cmp.op)
          OP_SMAC: begin
            acc    <= sum;
            result <= sum;
            if (ovf_det) acc_ovf <= 1'b1;
          end
          OP_ACLR: begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            result  <= '0;
          end
          default: result <= cmp.prod;
        endcase
      end
    end

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + CW'(vld_pipe[i]);
  end
endmodule

// File: tb/tb_pipe_mac.sv
// Bench for pipe_mac: fixed vector table, hand-written reset/streaming sequences,
// and a random stream, all checked against a queue-based completion model.
module tb_pipe_mac;
  localparam int W  = 8;
  localparam int S  = 3;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(S + 2);

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          done, acc_ovf;
  logic [PW-1:0] result;
  logic [CW-1:0] inflight;

  pipe_mac #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b), .flush(flush),
    .done(done), .result(result), .acc_ovf(acc_ovf), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] op;
    logic [W-1:0] a, b;
  } item_t;

  typedef struct {
    logic s; logic [1:0] o; logic [W-1:0] a, b; logic f;
    logic ed; logic [PW-1:0] er; logic eo; logic [CW-1:0] ei;
  } vec_t;

  item_t         q[$];
  logic [PW-1:0] m_acc = '0, m_res = '0;
  logic          m_ovf = 1'b0, m_done = 1'b0;
  int            cyc = 0, n_tests = 0, n_fail = 0;
  vec_t          vt[35];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic void apply(input item_t it);
    longint pa, pb, p;
    logic [PW-1:0] pr, s;
    if (it.op == 2'b00) begin
      pa = longint'(it.a); pb = longint'(it.b);
    end else begin
      pa = longint'($signed(it.a)); pb = longint'($signed(it.b));
    end
    p  = pa * pb;
    pr = p[PW-1:0];
    case (it.op)
      2'b10: begin
        s = m_acc + pr;
        if (m_acc[PW-1] == pr[PW-1] && s[PW-1] != m_acc[PW-1]) m_ovf = 1'b1;
        m_acc = s;
        m_res = s;
      end
      2'b11: begin m_acc = '0; m_ovf = 1'b0; m_res = '0; end
      default: m_res = pr;
    endcase
  endfunction

  task automatic step(input logic s, input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic f);
    item_t it;
    start = s; op = o; a = ia; b = ib; flush = f;
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (f) q.delete();
    else if (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front();
      m_done = 1'b1;
      apply(it);
    end
    if (s) q.push_back('{due: cyc + S + 1, op: o, a: ia, b: ib});
    #1;
    chk("done", 32'(done), 32'(m_done));
    chk("result", 32'(result), 32'(m_res));
    chk("acc_ovf", 32'(acc_ovf), 32'(m_ovf));
    chk("inflight", 32'(inflight), 32'(q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_ovf"}, 32'(acc_ovf), 32'd0);
    chk({tag, "_inflight"}, 32'(inflight), 32'd0);
  endtask

  function automatic vec_t v(input logic s, input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic f, input logic ed, input logic [PW-1:0] er, input logic eo,
                             input logic [CW-1:0] ei);
    v = '{s: s, o: o, a: ia, b: ib, f: f, ed: ed, er: er, eo: eo, ei: ei};
  endfunction

  function automatic vec_t vi(input logic ed, input logic [PW-1:0] er, input logic eo, input logic [CW-1:0] ei);
    vi = v(1'b0, 2'b00, '0, '0, 1'b0, ed, er, eo, ei);
  endfunction

  initial begin
    // UMUL latency/inflight
    vt[0]  = v(1, 2'b00, 8'hFF, 8'hFF, 0, 0, 16'h0000, 0, 1);
    vt[1]  = vi(0, 16'h0000, 0, 1);
    vt[2]  = vi(0, 16'h0000, 0, 1);
    vt[3]  = vi(0, 16'h0000, 0, 1);
    vt[4]  = vi(1, 16'hFE01, 0, 0);
    vt[5]  = vi(0, 16'hFE01, 0, 0);
    // SMUL stream including the most-negative corner
    vt[6]  = v(1, 2'b01, 8'h80, 8'h80, 0, 0, 16'hFE01, 0, 1);
    vt[7]  = v(1, 2'b01, 8'hFF, 8'h02, 0, 0, 16'hFE01, 0, 2);
    vt[8]  = v(1, 2'b01, 8'h7F, 8'h7F, 0, 0, 16'hFE01, 0, 3);
    vt[9]  = vi(0, 16'hFE01, 0, 3);
    vt[10] = vi(1, 16'h4000, 0, 2);
    vt[11] = vi(1, 16'hFFFE, 0, 1);
    vt[12] = vi(1, 16'h3F01, 0, 0);
    vt[13] = vi(0, 16'h3F01, 0, 0);
    // ACLR, SMAC chain into signed overflow, then ACLR again
    vt[14] = v(1, 2'b11, 8'h55, 8'hAA, 0, 0, 16'h3F01, 0, 1);
    vt[15] = v(1, 2'b10, 8'h7F, 8'h7F, 0, 0, 16'h3F01, 0, 2);
    vt[16] = v(1, 2'b10, 8'h7F, 8'h7F, 0, 0, 16'h3F01, 0, 3);
    vt[17] = v(1, 2'b10, 8'h7F, 8'h7F, 0, 0, 16'h3F01, 0, 4);
    vt[18] = vi(1, 16'h0000, 0, 3);
    vt[19] = vi(1, 16'h3F01, 0, 2);
    vt[20] = vi(1, 16'h7E02, 0, 1);
    vt[21] = vi(1, 16'hBD03, 1, 0);
    vt[22] = vi(0, 16'hBD03, 1, 0);
    vt[23] = v(1, 2'b11, 8'h00, 8'h00, 0, 0, 16'hBD03, 1, 1);
    vt[24] = vi(0, 16'hBD03, 1, 1);
    vt[25] = vi(0, 16'hBD03, 1, 1);
    vt[26] = vi(0, 16'hBD03, 1, 1);
    vt[27] = vi(1, 16'h0000, 0, 0);
    // flush together with a new issue
    vt[28] = v(1, 2'b00, 8'h01, 8'h01, 0, 0, 16'h0000, 0, 1);
    vt[29] = v(1, 2'b00, 8'h02, 8'h02, 0, 0, 16'h0000, 0, 2);
    vt[30] = v(1, 2'b00, 8'h03, 8'h05, 1, 0, 16'h0000, 0, 1);
    vt[31] = vi(0, 16'h0000, 0, 1);
    vt[32] = vi(0, 16'h0000, 0, 1);
    vt[33] = vi(0, 16'h0000, 0, 1);
    vt[34] = vi(1, 16'h000F, 0, 0);

    #2 rst_n = 1'b0;
    #1 chk_reset_state("por");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      step(vt[i].s, vt[i].o, vt[i].a, vt[i].b, vt[i].f);
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].ed));
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vt[i].er));
      chk($sformatf("vec%0d_ovf", i), 32'(acc_ovf), 32'(vt[i].eo));
      chk($sformatf("vec%0d_inflight", i), 32'(inflight), 32'(vt[i].ei));
    end

    // reset while an SMAC is in flight: it must never complete
    step(1'b1, 2'b10, 8'h02, 8'h03, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    q.delete(); m_acc = '0; m_ovf = 1'b0; m_res = '0;
    @(negedge clk) rst_n = 1'b1;
    idle(6);
    step(1'b1, 2'b10, 8'h01, 8'h01, 1'b0);
    idle(4);
    chk("post_rst_smac", 32'(result), 32'h0001);

    // long back-to-back SMAC stream, then clear
    for (int i = 0; i < 6; i++) step(1'b1, 2'b10, 8'h7F, 8'h7F, 1'b0);
    idle(5);
    chk("smac_stream_ovf", 32'(acc_ovf), 32'd1);
    step(1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0);
    idle(4);
    chk("aclr_ovf", 32'(acc_ovf), 32'd0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 15) == 0));
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
